imem_loader_ctrl: RTL
=====================

Name: imem_loader_ctrl

Overview:
- Debug-side load controller for the byte-organised instruction memory.
- Consumes the UART receive byte stream, assembles big-endian 32-bit instructions, and drives the memory's debug address, data and write-enable.
- Write enable is edge-triggered, so the controller owns setup/pulse sequencing.
- Stops on the HALT word or on memory exhaustion; reports status to the debug unit.

Parameters:
- BYTE_BITS, 8, width of one memory cell and one received byte.
- INST_BITS, 32, instruction width; 4 bytes per instruction.
- CELLS, 256, memory size in bytes; must be a multiple of 4.
- HALT_WORD, 32'hFFFF_FFFF, instruction value that terminates a load.

Ports:
- i_clk  in  1  system clock, posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle pulse; begins a load at address 0. Honoured in IDLE, DONE and ERROR; ignored otherwise.
- i_rx_data  in  BYTE_BITS  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid.
- o_dbg_addr  out  INST_BITS  byte address of the instruction being written.
- o_dbg_inst  out  INST_BITS  instruction to write.
- o_dbg_wr_en  out  1  write strobe; memory writes on its rising edge.
- o_busy  out  1  high in RECV, SETUP and WRITE.
- o_done  out  1  HALT word written.
- o_error  out  1  memory filled without HALT.
- o_words  out  $clog2(CELLS/4)+1  count of instructions written.

Behaviour:
- Reset (synchronous, i_rst high at a posedge):
  - state = IDLE.
  - All outputs 0; assembly register and byte counter cleared.
  - Reset overrides i_start and i_rx_valid in the same cycle.
  - Reset mid-load aborts immediately; o_dbg_wr_en drops the next cycle.
- All outputs are registered.
- States and transitions:
  - IDLE: i_start -> RECV. Clear o_dbg_addr, o_words, byte_cnt and asm_word. Any rx byte in the start cycle is dropped.
  - RECV: each i_rx_valid shifts asm_word = {asm_word[23:0], i_rx_data} and increments byte_cnt (2 bits, wraps). The first byte received lands in bits [31:24], i.e. memory[addr].
  - RECV -> SETUP: in the cycle the 4th byte arrives. The next edge loads o_dbg_inst with the completed word, including that byte.
  - SETUP: o_dbg_inst and o_dbg_addr stable, o_dbg_wr_en = 0; always -> WRITE next cycle. This guarantees one full cycle of setup before the write edge.
  - WRITE: o_dbg_wr_en = 1 for exactly one cycle; addr and inst unchanged.
  - Leaving WRITE:
    - o_words += 1.
    - If o_dbg_inst == HALT_WORD -> DONE; addr is not incremented.
    - Else if o_dbg_addr + 4 == CELLS -> ERROR.
    - Else o_dbg_addr += 4 -> RECV.
  - DONE: o_done = 1, o_busy = 0. i_start -> RECV and clears o_done.
  - ERROR: o_error = 1, o_busy = 0. i_start -> RECV and clears o_error.
- Rx bytes during SETUP and WRITE:
  - They are not dropped; they shift into asm_word for the next instruction and count in byte_cnt.
  - asm_word is independent of o_dbg_inst, so o_dbg_inst holds until the next SETUP.
  - If a word completes in WRITE and the exit goes to RECV, the controller proceeds directly to SETUP from RECV on the next cycle.
  - Rx bytes in DONE and ERROR are discarded.
- Pulse spacing: o_dbg_wr_en is low for at least 1 cycle between pulses; never high two consecutive cycles.
- HALT_WORD is written to memory before DONE is entered.
- Partial word at reset or restart: discarded, no write.
- o_dbg_addr is always a multiple of 4 and never exceeds CELLS-4.

Test Plan:
- Reset during load: assert i_rst during RECV. Required: all outputs 0 next cycle, IDLE. A following i_start plus 4 bytes writes at addr 0.
- Basic load: i_start, then bytes 20,08,00,05 then FF,FF,FF,FF (one byte every 10 cycles). Required:
  - wr_en pulse 1 with addr=0, inst=32'h2008_0005.
  - wr_en pulse 2 with addr=4, inst=32'hFFFF_FFFF.
  - o_done=1, o_words=2, o_busy=0.
- Setup timing: on every wr_en rising edge, addr/inst equal their values of the previous cycle; wr_en width is exactly 1 cycle.
- Back-to-back bytes: valid every cycle for 8 bytes 11..18. Required: inst 32'h1112_1314 at addr 0, then 32'h1516_1718 at addr 4. No byte lost (bytes arrive during SETUP/WRITE), and wr_en has a low gap between pulses.
- Overflow: CELLS=16, send 4 non-HALT words. Required: 4 writes at addr 0,4,8,12, then o_error=1, o_words=4, no 5th pulse. Further bytes are ignored.
- Restart: after DONE, i_start then 4 bytes AA,BB,CC,DD. Required: o_done clears, write at addr 0 with 32'hAABB_CCDD, o_words=1.

Source files
------------

// File: rtl/imem_loader_ctrl.sv
// Instruction-memory load controller: packs the UART byte stream into big-endian words and
// drives the memory's edge-triggered debug write port with one full setup cycle before each pulse.
module imem_loader_ctrl #(
    parameter int unsigned        BYTE_BITS = 8,
    parameter int unsigned        INST_BITS = 32,
    parameter int unsigned        CELLS     = 256,
    parameter logic [INST_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [BYTE_BITS-1:0]         i_rx_data,
    input  logic                         i_rx_valid,
    output logic [INST_BITS-1:0]         o_dbg_addr,
    output logic [INST_BITS-1:0]         o_dbg_inst,
    output logic                         o_dbg_wr_en,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_error,
    output logic [$clog2(CELLS/4):0]     o_words
);

    localparam int unsigned             WORDS_W   = $clog2(CELLS/4) + 1;
    localparam logic [INST_BITS-1:0]    ADDR_LAST = INST_BITS'(CELLS - 4);

    typedef enum logic [2:0] {StIdle, StRecv, StSetup, StWrite, StDone, StError} state_e;

    state_e               state_q, state_d;
    logic [INST_BITS-1:0] asm_q, asm_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 rdy_q, rdy_d;
    logic [INST_BITS-1:0] addr_q, addr_d;
    logic [INST_BITS-1:0] inst_q, inst_d;
    logic                 wr_q, wr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [WORDS_W-1:0]   words_q, words_d;
    logic [INST_BITS-1:0] asm_shift;
    logic                 loading;

    assign asm_shift = {asm_q[INST_BITS-BYTE_BITS-1:0], i_rx_data};
    assign loading   = (state_q == StRecv) || (state_q == StSetup) || (state_q == StWrite);

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        wr_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        words_d = words_q;

        // Bytes keep assembling during SETUP/WRITE; a word finished there is parked in rdy_q.
        if (i_rx_valid && loading) begin
            asm_d = asm_shift;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3 && state_q != StRecv) begin
                rdy_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (i_start) begin
                    state_d = StRecv;
                    addr_d  = '0;
                    words_d = '0;
                    cnt_d   = '0;
                    asm_d   = '0;
                    rdy_d   = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StRecv: begin
                if (rdy_q) begin
                    state_d = StSetup;
                    inst_d  = asm_q;
                    rdy_d   = 1'b0;
                end else if (i_rx_valid && cnt_q == 2'd3) begin
                    state_d = StSetup;
                    inst_d  = asm_shift;
                end
            end
            StSetup: begin
                state_d = StWrite;
                wr_d    = 1'b1;
            end
            StWrite: begin
                words_d = words_q + WORDS_W'(1);
                if (inst_q == HALT_WORD) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (addr_q == ADDR_LAST) begin
                    state_d = StError;
                    err_d   = 1'b1;
                end else begin
                    state_d = StRecv;
                    addr_d  = addr_q + INST_BITS'(4);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRecv) || (state_d == StSetup) || (state_d == StWrite);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            asm_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            words_q <= words_d;
        end
    end

    assign o_dbg_addr  = addr_q;
    assign o_dbg_inst  = inst_q;
    assign o_dbg_wr_en = wr_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = err_q;
    assign o_words     = words_q;

endmodule
